// File: rtl/imem_loader.sv
// Framed UART program loader: parses MAGIC / count / payload / checksum and
// writes assembled little-endian 32-bit words into the instruction memory.
module imem_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter int          TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code
);

    // Byte handshake: a byte moves when rx_valid && rx_ready at the rising
    // edge of clk; rx_valid may be held, rx_ready is a registered output.

    localparam int          CW        = ADDR_W + 1;
    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    localparam logic [1:0] CODE_COUNT   = 2'd1;
    localparam logic [1:0] CODE_CSUM    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t          state;
    logic [7:0]      cnt_lo;
    logic [CW-1:0]   words;
    logic [CW-1:0]   widx;
    logic [1:0]      bidx;
    logic [23:0]     word_buf;
    logic [7:0]      sum;
    logic [TW-1:0]   tcnt;

    logic            accept;
    logic [15:0]     n_full;
    logic            too_big;
    logic [CW-1:0]   widx_nxt;
    logic [31:0]     word_nxt;
    logic            timed_out;

    assign accept    = rx_valid && rx_ready;
    assign n_full    = {rx_data, cnt_lo};
    assign too_big   = {16'd0, n_full} > MAX_WORDS;
    assign widx_nxt  = widx + 1'b1;
    // Newest byte enters the top lane, so byte0 ends up in bits 7:0.
    assign word_nxt  = {rx_data, word_buf};
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'd0;
            cnt_lo     <= '0;
            words      <= '0;
            widx       <= '0;
            bidx       <= '0;
            word_buf   <= '0;
            sum        <= '0;
            tcnt       <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept && rx_data == MAGIC) begin
                        state      <= ST_CNT_LO;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        error_code <= 2'd0;
                        cpu_hold   <= 1'b1;
                        tcnt       <= '0;
                    end
                end

                ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CSUM: begin
                    if (accept) begin
                        tcnt <= '0;
                        case (state)
                            ST_CNT_LO: begin
                                cnt_lo <= rx_data;
                                state  <= ST_CNT_HI;
                            end
                            ST_CNT_HI: begin
                                sum   <= '0;
                                widx  <= '0;
                                bidx  <= '0;
                                words <= CW'(n_full);
                                if (too_big) begin
                                    state      <= ST_ERROR;
                                    error      <= 1'b1;
                                    error_code <= CODE_COUNT;
                                    cpu_hold   <= 1'b0;
                                    rx_ready   <= 1'b0;
                                end else if (n_full == 16'd0) begin
                                    state <= ST_CSUM;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                word_buf <= word_nxt[31:8];
                                sum      <= sum + rx_data;
                                bidx     <= bidx + 1'b1;
                                if (bidx == 2'd3) begin
                                    state     <= ST_WRITE;
                                    rx_ready  <= 1'b0;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= widx[ADDR_W-1:0];
                                    mem_wdata <= word_nxt;
                                end
                            end
                            ST_CSUM: begin
                                cpu_hold <= 1'b0;
                                rx_ready <= 1'b0;
                                if (rx_data == sum) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state      <= ST_ERROR;
                                    error      <= 1'b1;
                                    error_code <= CODE_CSUM;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timed_out) begin
                        // Words already written stay in memory.
                        state      <= ST_ERROR;
                        error      <= 1'b1;
                        error_code <= CODE_TIMEOUT;
                        cpu_hold   <= 1'b0;
                        rx_ready   <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_WRITE: begin
                    widx     <= widx_nxt;
                    rx_ready <= 1'b1;
                    state    <= (widx_nxt == words) ? ST_CSUM : ST_DATA;
                end

                ST_DONE, ST_ERROR: begin
                    rx_ready <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: begin
                    rx_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes 32-bit instruction words into the instruction memory's write port. It sits between the board UART receiver and the instruction memory. It parses a framed download, assembles little-endian words, and issues one write per word. It also holds the CPU in reset while a download is in progress, and reports completion or a failure code.

## Interface
- ADDR_W, 12: instruction memory word-address width; max words = 2^ADDR_W
- MAGIC, 8'hA5: frame start byte
- TIMEOUT, 100000: max clk cycles between accepted bytes inside a frame
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  32  word to write
- cpu_hold  out  1  high while a frame is being loaded
- done  out  1  sticky: last frame loaded and checksum matched
- error  out  1  sticky: last frame failed
- error_code  out  2  0 none, 1 count too large, 2 checksum mismatch, 3 timeout

## Operation
- Frame format: MAGIC, CNT_LO, CNT_HI, then N = {CNT_HI,CNT_LO} words of 4 bytes each (byte0 = bits 7:0 first), then CSUM.
- CSUM = sum of all payload bytes mod 256; header bytes are excluded.
- Byte accepted = rx_valid && rx_ready at the clk rising edge.
- States: IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE: non-MAGIC bytes are accepted and discarded. MAGIC moves to CNT_LO, clears done/error/error_code, and sets cpu_hold.
- CNT_LO: latch the byte, go to CNT_HI.
- CNT_HI: latch the byte.
  - N > 2^ADDR_W: go to ERROR with code 1.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA with word index 0, byte index 0, and running sum 0.
- DATA: shift each byte into its lane and add it to the running sum (8-bit wrap).
  - On the 4th byte, go to WRITE.
- WRITE: lasts one cycle. mem_we=1, mem_addr=word index, mem_wdata=assembled word, rx_ready=0.
  - Then increment the word index. If the index equals N, go to CSUM; else go to DATA.
- CSUM: compare the accepted byte to the running sum.
  - Equal: go to DONE.
  - Not equal: go to ERROR with code 2.
- DONE/ERROR: cpu_hold=0. The corresponding flag stays high. Next cycle return to IDLE; done/error/error_code stay high until the next MAGIC is accepted.
- Timeout: in CNT_LO, CNT_HI, DATA, or CSUM, a counter increments each cycle with no accepted byte and resets on acceptance.
  - When it reaches TIMEOUT, go to ERROR with code 3.
  - Words already written are not rolled back.
- MAGIC bytes inside a frame are treated as ordinary data; there is no resync.
- Reset mid-frame: all state is discarded. Partial words are never written.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, error_code=0; state IDLE.
- rx_ready=1 in every state except WRITE, DONE, ERROR, and while reset is asserted.
- mem_we rises the cycle after the 4th byte of a word is accepted. It is high for exactly one cycle.
- mem_addr/mem_wdata are registered and stable while mem_we=1.
- Minimum frame time: 3 + 5N + 1 cycles when rx_valid is held high.
- cpu_hold rises the cycle after MAGIC is accepted. It falls on entry to DONE or ERROR.
- done/error rise on entry to DONE/ERROR, one cycle after the CSUM byte or the failing event.
- Word index is ADDR_W+1 bits wide so that N = 2^ADDR_W terminates without wraparound. mem_addr takes the low ADDR_W bits.

## Test plan
- Basic load: A5 02 00 13 00 00 00 93 00 10 00, CSUM = 0x13+0x93+0x10 = B6.
  - Required: writes addr0=00000013 and addr1=00100093.
  - Required: done=1, error=0, cpu_hold pulse ends after CSUM.
- Checksum fail: same frame with CSUM=B7.
  - Required: both writes occur, then error=1, error_code=2, done=0.
- Count too large with ADDR_W=12: A5 01 10 (N=4097).
  - Required: error_code=1 and no mem_we.
  - Boundary case N=4096: the final write is at addr 0xFFF, then done.
- Timeout with TIMEOUT=50: A5 01 00 AA, then idle.
  - Required: error_code=3 exactly 50 cycles after AA is accepted; no write.
- Zero-length and garbage prefix: 00 FF A5 00 00 00.
  - Required: leading bytes discarded, no writes, done=1.
  - A following MAGIC clears done the cycle after it is accepted.
- Reset mid-word: assert reset after 2 data bytes.
  - Required: all outputs return to reset values immediately, and no mem_we ever follows.
